// File: rtl/mc_mem_if.sv
// Unified instruction/data memory port between the multi-cycle controller and memory.
// A request (MemRd or MemWr) is held steady until a cycle with mem_ready=1 completes it; the request never depends on mem_ready.
interface mc_mem_if;
    logic mem_ready;
    logic MemRd;
    logic MemWr;
    logic IorD;

    modport master (output MemRd, MemWr, IorD, input mem_ready);
    modport slave  (input MemRd, MemWr, IorD, output mem_ready);
endinterface

// File: rtl/mc_control.sv
// Multi-cycle CPU controller: FETCH/DECODE/EXEC/MEM/WB sequencing, memory wait/timeout,
// synchronised IRQ entry at instruction boundaries and bus-error/undefined-instruction exceptions.
module mc_control #(
    parameter int IRQ_SYNC    = 2,
    parameter int MEM_TIMEOUT = 15,
    parameter int TO_W        = 4
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic [31:0]     Instruct,
    input  logic            IRQ,
    input  logic            PC31,
    mc_mem_if.master        mem,
    output logic            PCWr,
    output logic            IRWr,
    output logic            RegWr,
    output logic [2:0]      PCSrc,
    output logic [1:0]      RegDst,
    output logic [1:0]      MemToReg,
    output logic [2:0]      state
);

    typedef enum logic [2:0] {
        S_FETCH   = 3'd0,
        S_DECODE  = 3'd1,
        S_EXEC    = 3'd2,
        S_MEM     = 3'd3,
        S_WB      = 3'd4,
        S_IRQ_ENT = 3'd5,
        S_EXC_ENT = 3'd6
    } state_t;

    state_t st, nxt;
    logic [IRQ_SYNC-1:0] irq_sync;
    logic irq_s;
    logic [TO_W-1:0] to_cnt, cnt_inc;
    logic waiting, timeout;
    logic mem_rd, mem_wr, iord;

    logic [5:0] op, funct;
    logic [4:0] rt, rd, dest;
    logic is_rtype, is_lw, is_sw, is_branch, is_j, is_jal, is_jr, is_jalr;
    logic legal_r, is_legal, wb_en;

    assign op    = Instruct[31:26];
    assign funct = Instruct[5:0];
    assign rt    = Instruct[20:16];
    assign rd    = Instruct[15:11];

    always_comb begin
        is_rtype  = (op == 6'h00);
        is_jr     = is_rtype && (funct == 6'h08);
        is_jalr   = is_rtype && (funct == 6'h09);
        is_lw     = (op == 6'h23);
        is_sw     = (op == 6'h2b);
        is_branch = (op == 6'h01) || (op inside {[6'h04:6'h07]});
        is_j      = (op == 6'h02);
        is_jal    = (op == 6'h03);
        legal_r   = funct inside {6'h00, 6'h02, 6'h03, 6'h08, 6'h09, [6'h20:6'h27], 6'h2a, 6'h2b};
        is_legal  = is_rtype ? legal_r
                             : (op inside {[6'h01:6'h0f], 6'h23, 6'h2b});
        dest      = is_rtype ? rd : rt;
        // The all-zero word and writes to $zero never touch the register file.
        wb_en     = (Instruct != 32'd0) && (dest != 5'd0);
    end

    assign irq_s = irq_sync[IRQ_SYNC-1];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            irq_sync <= '0;
        end else begin
            irq_sync[0] <= IRQ;
            for (int i = 1; i < IRQ_SYNC; i++) irq_sync[i] <= irq_sync[i-1];
        end
    end

    // Saturating wait counter; timeout fires on the cycle the count would reach MEM_TIMEOUT.
    assign waiting = (st == S_FETCH) || (st == S_MEM);
    assign cnt_inc = (to_cnt == '1) ? to_cnt : to_cnt + 1'b1;
    assign timeout = waiting && !mem.mem_ready && (cnt_inc == TO_W'(MEM_TIMEOUT));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            st     <= S_FETCH;
            to_cnt <= '0;
        end else begin
            st <= nxt;
            if (nxt != st || timeout) to_cnt <= '0;
            else if (waiting && !mem.mem_ready) to_cnt <= cnt_inc;
        end
    end

    always_comb begin
        nxt      = st;
        PCWr     = 1'b0;
        IRWr     = 1'b0;
        iord     = 1'b0;
        mem_rd   = 1'b0;
        mem_wr   = 1'b0;
        RegWr    = 1'b0;
        PCSrc    = 3'd0;
        RegDst   = 2'd0;
        MemToReg = 2'd0;
        case (st)
            S_FETCH: begin
                mem_rd = 1'b1;
                if (mem.mem_ready) begin
                    IRWr = 1'b1;
                    PCWr = 1'b1;
                    nxt  = S_DECODE;
                end else if (timeout) begin
                    nxt = PC31 ? S_FETCH : S_EXC_ENT;
                end
            end
            S_DECODE: begin
                if (!is_legal) nxt = PC31 ? S_FETCH : S_EXC_ENT;
                else           nxt = S_EXEC;
            end
            S_EXEC: begin
                if (is_branch) begin
                    PCWr  = 1'b1;
                    PCSrc = 3'd1;
                    nxt   = S_FETCH;
                end else if (is_j || is_jal || is_jr || is_jalr) begin
                    PCWr  = 1'b1;
                    PCSrc = (is_j || is_jal) ? 3'd2 : 3'd3;
                    if (is_jal || is_jalr) begin
                        RegWr    = 1'b1;
                        RegDst   = 2'd2;
                        MemToReg = 2'd2;
                    end
                    nxt = S_FETCH;
                end else if (is_lw || is_sw) begin
                    nxt = S_MEM;
                end else begin
                    nxt = S_WB;
                end
            end
            S_MEM: begin
                iord   = 1'b1;
                mem_rd = is_lw;
                mem_wr = is_sw;
                if (mem.mem_ready)  nxt = is_lw ? S_WB : S_FETCH;
                else if (timeout)   nxt = PC31 ? S_FETCH : S_EXC_ENT;
            end
            S_WB: begin
                RegWr    = wb_en;
                RegDst   = is_rtype ? 2'd0 : 2'd1;
                MemToReg = is_lw ? 2'd1 : 2'd0;
                nxt      = S_FETCH;
            end
            S_IRQ_ENT: begin
                RegWr    = 1'b1;
                RegDst   = 2'd3;
                MemToReg = 2'd3;
                PCWr     = 1'b1;
                PCSrc    = 3'd4;
                nxt      = S_FETCH;
            end
            S_EXC_ENT: begin
                RegWr    = 1'b1;
                RegDst   = 2'd3;
                MemToReg = 2'd2;
                PCWr     = 1'b1;
                PCSrc    = 3'd5;
                nxt      = S_FETCH;
            end
            default: nxt = S_FETCH;
        endcase
        // Instruction boundary: entry sequences return straight to FETCH so $k0 is not clobbered.
        if (nxt == S_FETCH && irq_s && !PC31 &&
            (st == S_DECODE || st == S_EXEC || st == S_MEM || st == S_WB))
            nxt = S_IRQ_ENT;
        if (!reset_n) begin
            PCWr     = 1'b0;
            IRWr     = 1'b0;
            iord     = 1'b0;
            mem_rd   = 1'b0;
            mem_wr   = 1'b0;
            RegWr    = 1'b0;
            PCSrc    = 3'd0;
            RegDst   = 2'd0;
            MemToReg = 2'd0;
        end
    end

    assign mem.MemRd = mem_rd;
    assign mem.MemWr = mem_wr;
    assign mem.IorD  = iord;
    assign state     = st;

endmodule

// File: tb/tb_mc_control.sv
// Directed bench for mc_control: expected output words are queued per cycle and
// compared against the packed DUT outputs on the falling edge.
module tb_mc_control;

    localparam logic [31:0] I_J    = 32'h0800_0000;
    localparam logic [31:0] I_ADD  = 32'h0022_1820;
    localparam logic [31:0] I_LW   = 32'h8C22_0004;
    localparam logic [31:0] I_SW   = 32'hAC22_0004;
    localparam logic [31:0] I_UND  = 32'hFC00_0000;
    localparam logic [31:0] I_JAL  = 32'h0C00_0010;
    localparam logic [31:0] I_BEQ  = 32'h1022_0003;

    // {state, PCWr, IRWr, IorD, MemRd, MemWr, RegWr, PCSrc, RegDst, MemToReg}
    localparam logic [15:0] ZERO    = 16'h0000;
    localparam logic [15:0] F_WAIT  = {3'd0, 6'b000100, 3'd0, 2'd0, 2'd0};
    localparam logic [15:0] F_RDY   = {3'd0, 6'b110100, 3'd0, 2'd0, 2'd0};
    localparam logic [15:0] DEC     = {3'd1, 6'b000000, 3'd0, 2'd0, 2'd0};
    localparam logic [15:0] EX_NONE = {3'd2, 6'b000000, 3'd0, 2'd0, 2'd0};
    localparam logic [15:0] EX_J    = {3'd2, 6'b100000, 3'd2, 2'd0, 2'd0};
    localparam logic [15:0] EX_JAL  = {3'd2, 6'b100001, 3'd2, 2'd2, 2'd2};
    localparam logic [15:0] EX_BR   = {3'd2, 6'b100000, 3'd1, 2'd0, 2'd0};
    localparam logic [15:0] MEM_RD  = {3'd3, 6'b001100, 3'd0, 2'd0, 2'd0};
    localparam logic [15:0] MEM_WR  = {3'd3, 6'b001010, 3'd0, 2'd0, 2'd0};
    localparam logic [15:0] WB_R    = {3'd4, 6'b000001, 3'd0, 2'd0, 2'd0};
    localparam logic [15:0] WB_LW   = {3'd4, 6'b000001, 3'd0, 2'd1, 2'd1};
    localparam logic [15:0] WB_NOP  = {3'd4, 6'b000000, 3'd0, 2'd0, 2'd0};
    localparam logic [15:0] IRQE    = {3'd5, 6'b100001, 3'd4, 2'd3, 2'd3};
    localparam logic [15:0] EXC     = {3'd6, 6'b100001, 3'd5, 2'd3, 2'd2};

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [31:0] Instruct = 32'd0;
    logic        IRQ = 1'b0;
    logic        PC31 = 1'b0;
    logic        mem_ready = 1'b0;
    logic        PCWr, IRWr, RegWr;
    logic [2:0]  PCSrc, state;
    logic [1:0]  RegDst, MemToReg;
    logic [15:0] obs;

    logic [15:0] exp_q[$];
    string       tag_q[$];
    int          vectors = 0;
    int          miscompares = 0;

    mc_mem_if mem ();
    assign mem.mem_ready = mem_ready;

    mc_control #(.IRQ_SYNC(2), .MEM_TIMEOUT(15), .TO_W(4)) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .Instruct (Instruct),
        .IRQ      (IRQ),
        .PC31     (PC31),
        .mem      (mem),
        .PCWr     (PCWr),
        .IRWr     (IRWr),
        .RegWr    (RegWr),
        .PCSrc    (PCSrc),
        .RegDst   (RegDst),
        .MemToReg (MemToReg),
        .state    (state)
    );

    always #5 clk = ~clk;

    assign obs = {state, PCWr, IRWr, mem.IorD, mem.MemRd, mem.MemWr, RegWr, PCSrc, RegDst, MemToReg};

    task automatic check_now();
        logic [15:0] e;
        string t;
        e = exp_q.pop_front();
        t = tag_q.pop_front();
        vectors++;
        assert (obs === e) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", t, obs, e);
        end
    endtask

    task automatic expect_out(input logic [15:0] e, input string tag);
        exp_q.push_back(e);
        tag_q.push_back(tag);
    endtask

    // One clock cycle: drive mem_ready, check at negedge, return just after the next posedge.
    task automatic cyc(input logic mr, input logic [15:0] e, input string tag);
        mem_ready = mr;
        expect_out(e, tag);
        @(negedge clk);
        check_now();
        @(posedge clk);
        #1;
    endtask

    task automatic fetch_decode(input logic [31:0] ins, input string tag);
        Instruct = ins;
        cyc(1'b1, F_RDY, {tag, "_fetch"});
        cyc(1'b1, DEC, {tag, "_decode"});
    endtask

    initial begin
        // Reset held with IRQ and mem_ready asserted: everything stays quiet.
        IRQ = 1'b1;
        Instruct = I_J;
        for (int i = 0; i < 3; i++) cyc(1'b1, ZERO, "reset_quiet");
        reset_n = 1'b1;
        cyc(1'b1, F_RDY, "rst_fetch");
        cyc(1'b1, DEC, "rst_decode");
        IRQ = 1'b0;
        cyc(1'b1, EX_J, "rst_j_exec");
        cyc(1'b1, IRQE, "rst_irq_ent");
        cyc(1'b0, F_WAIT, "rst_after_irq");

        fetch_decode(I_ADD, "add");
        cyc(1'b1, EX_NONE, "add_exec");
        cyc(1'b1, WB_R, "add_wb");

        fetch_decode(I_LW, "lw");
        cyc(1'b1, EX_NONE, "lw_exec");
        for (int i = 0; i < 3; i++) cyc(1'b0, MEM_RD, "lw_mem_wait");
        cyc(1'b1, MEM_RD, "lw_mem_ready");
        cyc(1'b1, WB_LW, "lw_wb");

        fetch_decode(32'd0, "nop");
        cyc(1'b1, EX_NONE, "nop_exec");
        cyc(1'b1, WB_NOP, "nop_wb");

        fetch_decode(I_SW, "sw");
        cyc(1'b1, EX_NONE, "sw_exec");
        cyc(1'b1, MEM_WR, "sw_mem");

        // Fetch stall: 15 wait cycles, then bus error.
        for (int i = 0; i < 15; i++) cyc(1'b0, F_WAIT, "fetch_stall");
        cyc(1'b0, EXC, "fetch_bus_err");
        cyc(1'b0, F_WAIT, "fetch_after_exc");

        fetch_decode(I_UND, "und_user");
        cyc(1'b1, EXC, "und_user_exc");
        cyc(1'b0, F_WAIT, "und_user_after");

        PC31 = 1'b1;
        fetch_decode(I_UND, "und_kern");
        cyc(1'b0, F_WAIT, "und_kern_nop");
        PC31 = 1'b0;

        // IRQ raised at fetch reaches irq_s by EXEC and is taken at the jal boundary.
        Instruct = I_JAL;
        IRQ = 1'b1;
        cyc(1'b1, F_RDY, "jal_fetch");
        cyc(1'b1, DEC, "jal_decode");
        IRQ = 1'b0;
        cyc(1'b1, EX_JAL, "jal_exec");
        cyc(1'b1, IRQE, "jal_irq_ent");
        cyc(1'b0, F_WAIT, "jal_after_irq");

        fetch_decode(I_BEQ, "beq");
        cyc(1'b1, EX_BR, "beq_exec");
        cyc(1'b0, F_WAIT, "beq_after");

        // Ready on the same cycle the count would time out: ready wins.
        fetch_decode(I_LW, "lw_edge");
        cyc(1'b1, EX_NONE, "lw_edge_exec");
        for (int i = 0; i < 14; i++) cyc(1'b0, MEM_RD, "lw_edge_wait");
        cyc(1'b1, MEM_RD, "lw_edge_ready");
        cyc(1'b1, WB_LW, "lw_edge_wb");

        fetch_decode(I_LW, "lw_kto");
        cyc(1'b1, EX_NONE, "lw_kto_exec");
        PC31 = 1'b1;
        for (int i = 0; i < 15; i++) cyc(1'b0, MEM_RD, "lw_kto_wait");
        cyc(1'b0, F_WAIT, "lw_kto_drop");
        PC31 = 1'b0;

        fetch_decode(I_SW, "sw_to");
        cyc(1'b1, EX_NONE, "sw_to_exec");
        for (int i = 0; i < 15; i++) cyc(1'b0, MEM_WR, "sw_to_wait");
        cyc(1'b0, EXC, "sw_to_bus_err");
        cyc(1'b0, F_WAIT, "sw_to_after");

        // Reset mid-access: the memory request drops without waiting for a clock.
        fetch_decode(I_LW, "lw_rst");
        cyc(1'b1, EX_NONE, "lw_rst_exec");
        cyc(1'b0, MEM_RD, "lw_rst_mem");
        #2;
        reset_n = 1'b0;
        #1;
        expect_out(ZERO, "async_reset_drop");
        check_now();
        @(negedge clk);
        expect_out(ZERO, "async_reset_hold");
        check_now();
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        cyc(1'b0, F_WAIT, "post_reset_fetch");
        cyc(1'b1, F_RDY, "post_reset_ready");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
